uart_tx: RTL
============

Name: uart_tx

Overview:
- 16x-oversample-tick-driven UART transmitter. Serialises 8N1 frames (start, LSB-first data, stop) onto the tx line.
- Companion to the SoC UART receiver. Shares the same oversample_tick generator, so one baud generator serves both directions.
- A one-entry holding register decouples the bus-side valid/ready handshake from the serial shifter. This allows back-to-back frames with no idle gap.

Parameters:
- OVERSAMPLE, 16: oversample ticks per bit period (>=2). One bit = OVERSAMPLE ticks.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  synchronous active-low reset, sampled on rising clk
- oversample_tick  input  1  one-clk-wide enable pulse, OVERSAMPLE per bit period
- tx_data  input  8  byte to send, sampled when tx_valid & tx_ready
- tx_valid  input  1  producer has a byte
- tx_ready  output  1  holding register empty; accepts a byte this cycle
- tx  output  1  serial line, idle high
- tx_busy  output  1  shifter in a non-IDLE state
- tx_done  output  1  one-clk pulse at end of each frame's last stop bit

Behaviour:
- Reset (reset_n=0 at clk edge):
  - tx=1, tx_ready=1, tx_busy=0, tx_done=0.
  - Holding register empty, state=IDLE, tick counter=0, bit index=0.
  - Reset mid-frame aborts the frame immediately. tx returns high on the next edge and the pending byte is discarded.
- Handshake (every clk, independent of the tick):
  - tx_ready = ~hold_full (registered flag).
  - When tx_valid & tx_ready: latch tx_data into the holding register and set hold_full.
  - tx_data and tx_valid are ignored while tx_ready=0.
- FSM: states IDLE, START, DATA, [PARITY], STOP. Advances only on clk edges where oversample_tick=1.
- Bit timing and output:
  - Counter runs 0..OVERSAMPLE-1 in every non-IDLE state. A bit ends on the tick where counter==OVERSAMPLE-1; the counter then wraps to 0.
  - tx is registered. It changes on the same edge as the state transition, so each bit is held for exactly OVERSAMPLE ticks.
- IDLE:
  - tx=1.
  - On a tick with hold_full=1: move the holding register into the shift register, clear hold_full, drive tx=0, go to START with counter=0.
  - A byte accepted on a non-tick cycle waits for the next tick, giving up to 1 tick of latency.
- START: at bit end, drive tx=data[0], bit index=0, go to DATA.
- DATA:
  - At bit end with index<7: index+1, tx=data[index+1].
  - At index==7: go to PARITY if enabled, otherwise to STOP with tx=1.
- STOP:
  - tx=1 for STOP_BITS*OVERSAMPLE ticks.
  - On the final tick, pulse tx_done for that single clk cycle.
  - If hold_full=1: load the shifter, clear hold_full, tx=0, go to START. There is no idle tick between frames.
  - Otherwise go to IDLE.
- tx_busy=1 in START, DATA, PARITY and STOP.
- Ordering and simultaneity:
  - The holding register may fill during any state. The byte in flight is never overwritten.
  - A handshake and a shifter load in the same cycle cannot coincide, because tx_ready reflects the pre-edge hold_full.
  - The load clears the flag and ready goes high one cycle later.
- oversample_tick is ignored while reset_n=0. Arbitrary gaps between ticks simply stretch the bit period.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - Adds parameter PARITY_ODD (default 0 = even) and a PARITY state of OVERSAMPLE ticks between DATA and STOP.
  - tx during PARITY = XOR of the 8 data bits, inverted when PARITY_ODD=1.
  - The parity value is computed at shifter load time.
- Undefined: no PARITY state and no PARITY_ODD parameter. Frame is 8N1/8N2 only.

Test Plan:
- Single byte 0x55, tick every 4 clks, OVERSAMPLE=16 -> tx: 16 ticks low, then data bits 1,0,1,0,1,0,1,0 (16 ticks each), then 16 ticks high. tx_done pulses once at tick 160; tx_busy drops after it; tx_ready high again 1 clk after the load.
- Back-to-back 0xA5 then 0x3C (second offered while the first is in DATA) -> second accepted immediately. Its start bit begins on the tick right after frame 1's last stop tick (tick 160), with no idle high gap. Two tx_done pulses, 160 ticks apart.
- Third byte offered while holding is full and the shifter is busy -> tx_ready=0, byte not latched until frame 1 completes. Bytes emerge in order with none lost or duplicated.
- reset_n low for 1 clk mid-DATA of 0xFF -> next edge gives tx=1, tx_busy=0, tx_ready=1, no tx_done. A new byte 0x00 sent afterwards produces a correct full frame.
- STOP_BITS=2, byte 0x80 -> stop high for 32 ticks, tx_done at tick 176.
- UART_TX_PARITY_EN, PARITY_ODD=0, byte 0x07 -> parity bit 1, inserted after bit 7 for 16 ticks. With PARITY_ODD=1 the parity bit is 0.

Source files
------------

// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter driven by a shared 16x oversample tick, with a one-entry holding register.
// Optional even/odd parity bit is compiled in with `define UART_TX_PARITY_EN.
module uart_tx #(
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
`ifdef UART_TX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       oversample_tick,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);
  localparam int CW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
`ifdef UART_TX_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      bit_idx, idx_n;
  logic [7:0]      shreg, shreg_n;
  logic [7:0]      hold, hold_n;
  logic            hold_full, hold_full_n;
  logic            tx_q, tx_n;
  logic            done_q, done_n;
  logic            bit_end, load;
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_n;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= idx_n;
      shreg     <= shreg_n;
      hold      <= hold_n;
      hold_full <= hold_full_n;
      tx_q      <= tx_n;
      done_q    <= done_n;
`ifdef UART_TX_PARITY_EN
      par_q     <= par_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    idx_n       = bit_idx;
    shreg_n     = shreg;
    hold_n      = hold;
    hold_full_n = hold_full;
    tx_n        = tx_q;
    done_n      = 1'b0;
    load        = 1'b0;
    bit_end     = (cnt == CW'(OVERSAMPLE - 1));
`ifdef UART_TX_PARITY_EN
    par_n       = par_q;
`endif

    // Accept and load are mutually exclusive: one needs hold_full=0, the other hold_full=1.
    if (tx_valid && !hold_full) begin
      hold_n      = tx_data;
      hold_full_n = 1'b1;
    end

    if (oversample_tick) begin
      if (state != IDLE) cnt_n = bit_end ? '0 : cnt + CW'(1);
      case (state)
        IDLE:  if (hold_full) load = 1'b1;
        START: if (bit_end) begin
          state_n = DATA;
          idx_n   = '0;
          tx_n    = shreg[0];
        end
        DATA: if (bit_end) begin
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            tx_n    = par_q;
`else
            state_n = STOP;
            idx_n   = '0;
            tx_n    = 1'b1;
`endif
          end else begin
            idx_n = bit_idx + 3'd1;
            tx_n  = shreg[bit_idx + 3'd1];
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (bit_end) begin
          state_n = STOP;
          idx_n   = '0;
          tx_n    = 1'b1;
        end
`endif
        STOP: if (bit_end) begin
          // bit_idx doubles as the stop-bit counter
          if (bit_idx == 3'(STOP_BITS - 1)) begin
            done_n = 1'b1;
            if (hold_full) load = 1'b1;
            else begin
              state_n = IDLE;
              tx_n    = 1'b1;
            end
          end else begin
            idx_n = bit_idx + 3'd1;
          end
        end
        default: state_n = IDLE;
      endcase

      if (load) begin
        shreg_n     = hold;
        hold_full_n = 1'b0;
        tx_n        = 1'b0;
        state_n     = START;
        cnt_n       = '0;
        idx_n       = '0;
`ifdef UART_TX_PARITY_EN
        par_n       = (^hold) ^ PARITY_ODD;
`endif
      end
    end
  end

  assign tx_ready = ~hold_full;
  assign tx       = tx_q;
  assign tx_busy  = (state != IDLE);
  assign tx_done  = done_q;
endmodule
